// File: rtl/mygo_chan_pkg.sv
// rtl/mygo_chan_pkg.sv - shared channel types and constants for mygo process blocks
package mygo_chan_pkg;

    localparam int DEFAULT_DATA_W = 32;

    // Simulation stdout descriptor used by process trace messages
    localparam logic [31:0] STDOUT_FD = 32'h8000_0001;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_LOOP = 3'd1,
        S_RECV = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Counter width able to hold 0..count, never narrower than one bit
    function automatic int cnt_width(input int count);
        return (count < 1) ? 1 : $clog2(count + 1);
    endfunction

endpackage

// File: rtl/mygo_chan_tx_slot.sv
// rtl/mygo_chan_tx_slot.sv - output channel slot holding a word stable until accepted
module mygo_chan_tx_slot
    import mygo_chan_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              send_en,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              fire
);

    logic [DATA_W-1:0] data_q;

    // Capture the outgoing word; it is not touched again until the next load
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end
    end

    assign wdata  = data_q;
    // Valid is masked by reset so no transfer can complete in a reset cycle
    assign wvalid = send_en & rst;
    assign fire   = wvalid & wready;

endmodule

// File: rtl/mygo_proc_consumer_sum.sv
// rtl/mygo_proc_consumer_sum.sv - consumer process: sums COUNT channel words and sends the result
module mygo_proc_consumer_sum
    import mygo_chan_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int COUNT  = 4,
    parameter int CNT_W  = cnt_width(COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] chan_in_rdata,
    input  logic              chan_in_rvalid,
    output logic              chan_in_rready,
    output logic [DATA_W-1:0] chan_out_wdata,
    output logic              chan_out_wvalid,
    input  logic              chan_out_wready,
    output logic [CNT_W-1:0]  recv_count,
    output logic              done
);

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] sum;
    logic [CNT_W-1:0]  cnt_q;
    logic              more_to_recv;
    logic              in_fire;
    logic              out_fire;
    logic              load_result;

    assign more_to_recv   = (cnt_q < COUNT_C);
    assign chan_in_rready = rst & (state == S_RECV);
    assign in_fire        = chan_in_rready & chan_in_rvalid;
    assign load_result    = (state == S_LOOP) & ~more_to_recv;
    assign recv_count     = cnt_q;
    assign done           = (state == S_DONE);

    mygo_chan_tx_slot #(
        .DATA_W (DATA_W)
    ) u_tx_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_result),
        .load_data (sum),
        .send_en   (state == S_SEND),
        .wdata     (chan_out_wdata),
        .wvalid    (chan_out_wvalid),
        .wready    (chan_out_wready),
        .fire      (out_fire)
    );

    // Next-state decode; unknown encodings park in place like the done state
    always_comb begin
        state_next = state;
        case (state)
            S_INIT: state_next = S_LOOP;
            S_LOOP: state_next = more_to_recv ? S_RECV : S_SEND;
            S_RECV: if (chan_in_rvalid) state_next = S_LOOP;
            S_SEND: if (chan_out_wready) state_next = S_SEND == state ? S_DONE : state;
            S_DONE: state_next = S_DONE;
            default: state_next = state;
        endcase
    end

    // State register plus the wrapping accumulator and receive counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_INIT;
            sum   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_INIT) begin
                sum   <= '0;
                cnt_q <= '0;
            end else if (in_fire) begin
                sum   <= sum + chan_in_rdata;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Trace of channel traffic for simulation logs
    always @(posedge clk) begin
        if (in_fire) begin
            $display("consumer received %d", chan_in_rdata);
        end
        if (out_fire) begin
            $display("consumer sum %d", chan_out_wdata);
        end
    end
`endif

endmodule

// File: tb/tb_mygo_proc_consumer_sum.sv
// tb/tb_mygo_proc_consumer_sum.sv - self-checking bench for mygo_proc_consumer_sum
module tb_mygo_proc_consumer_sum;

    localparam int DATA_W = 32;
    localparam int COUNT  = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] chan_in_rdata = '0;
    logic              chan_in_rvalid = 1'b0;
    logic              chan_in_rready;
    logic [DATA_W-1:0] chan_out_wdata;
    logic              chan_out_wvalid;
    logic              chan_out_wready = 1'b1;
    logic [CNT_W-1:0]  recv_count;
    logic              done;

    always #5 clk = ~clk;

    mygo_proc_consumer_sum #(
        .DATA_W (DATA_W),
        .COUNT  (COUNT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .chan_in_rdata   (chan_in_rdata),
        .chan_in_rvalid  (chan_in_rvalid),
        .chan_in_rready  (chan_in_rready),
        .chan_out_wdata  (chan_out_wdata),
        .chan_out_wvalid (chan_out_wvalid),
        .chan_out_wready (chan_out_wready),
        .recv_count      (recv_count),
        .done            (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Upstream FIFO and output sink stimulus controls
    logic [DATA_W-1:0] fifo_q[$];
    int  gate_mode  = 0;
    int  wr_block   = 0;
    int  gate_phase = 0;

    // Transaction-level model of what the consumer must have done since reset
    int          m_cnt;
    logic [31:0] m_sum;
    bit          m_done;
    int          out_count;
    logic [31:0] last_out;
    int          wv_cycles;
    int          stall_rdy;
    bit          prev_wait;
    logic [31:0] prev_wdata;

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0; m_sum = 0; m_done = 0;
            out_count = 0; last_out = 0; wv_cycles = 0; stall_rdy = 0;
            prev_wait = 0;
        end else begin
            if (chan_in_rready && !chan_in_rvalid) stall_rdy++;
            if (chan_in_rvalid && chan_in_rready) begin
                m_cnt++;
                m_sum = m_sum + chan_in_rdata;
                void'(fifo_q.pop_front());
            end
            if (chan_out_wvalid) wv_cycles++;
            if (chan_out_wvalid && chan_out_wready) begin
                out_count++;
                last_out = chan_out_wdata;
                m_done = 1;
            end
            prev_wait  = chan_out_wvalid && !chan_out_wready;
            prev_wdata = chan_out_wdata;
        end
    end

    // Input drivers update away from the sampling edge
    always @(negedge clk) begin
        gate_phase = (gate_phase + 1) % 4;
        chan_in_rvalid = (fifo_q.size() > 0) && (gate_mode == 0 || gate_phase == 0);
        chan_in_rdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (chan_out_wvalid && wr_block > 0) begin
            chan_out_wready = 1'b0;
            wr_block--;
        end else begin
            chan_out_wready = 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        #2;
        check("recv_count", 64'(recv_count), 64'(m_cnt));
        check("done", 64'(done), 64'(m_done));
        if (!rst) begin
            check("rready_in_reset", 64'(chan_in_rready), 64'd0);
            check("wvalid_in_reset", 64'(chan_out_wvalid), 64'd0);
        end else begin
            if (m_cnt >= COUNT || m_done)
                check("no_excess_rready", 64'(chan_in_rready), 64'd0);
            if (chan_out_wvalid)
                check("wdata_is_sum", 64'(chan_out_wdata), 64'(m_sum));
            if (m_done)
                check("wvalid_after_done", 64'(chan_out_wvalid), 64'd0);
            if (prev_wait) begin
                check("wvalid_held", 64'(chan_out_wvalid), 64'd1);
                check("wdata_stable", 64'(chan_out_wdata), 64'(prev_wdata));
            end
        end
    end

    task automatic reset_and_load(input logic [31:0] words[$], input int gmode, input int wblock);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        fifo_q    = words;
        gate_mode = gmode;
        wr_block  = wblock;
        rst = 1'b1;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
    endtask

    int cyc;

    initial begin
        // Test 1: basic, also pins done latency
        reset_and_load('{32'd0, 32'd1, 32'd2, 32'd3}, 0, 0);
        #1;
        check("reset_recv_count", 64'(recv_count), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        wait_done("t1", cyc);
        check("t1_latency", 64'(cyc), 64'd11);
        check("t1_sum", 64'(last_out), 64'd6);
        check("t1_out_count", 64'(out_count), 64'd1);
        check("t1_wvalid_cycles", 64'(wv_cycles), 64'd1);
        check("t1_recv_count", 64'(recv_count), 64'd4);

        // Test 2: input stalls, rready must wait through them
        reset_and_load('{32'd10, 32'd20, 32'd30, 32'd40}, 1, 0);
        wait_done("t2", cyc);
        check("t2_sum", 64'(last_out), 64'd100);
        check("t2_accepts", 64'(m_cnt), 64'd4);
        check("t2_rready_in_stall", 64'(stall_rdy > 0), 64'd1);

        // Test 3: output backpressure for 5 cycles
        reset_and_load('{32'd3, 32'd5, 32'd7, 32'd11}, 0, 5);
        wait_done("t3", cyc);
        check("t3_sum", 64'(last_out), 64'd26);
        check("t3_wvalid_cycles", 64'(wv_cycles), 64'd6);
        check("t3_out_count", 64'(out_count), 64'd1);

        // Test 4: wrapping sum
        reset_and_load('{32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0}, 0, 0);
        wait_done("t4", cyc);
        check("t4_wrap_sum", 64'(last_out), 64'h1);

        // Test 5: reset after two words, then restart with fresh data
        reset_and_load('{32'd7, 32'd9, 32'd11, 32'd13}, 0, 0);
        for (int i = 0; i < 50 && m_cnt < 2; i++) @(posedge clk);
        check("t5_two_accepted", 64'(m_cnt), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        fifo_q = '{32'd5, 32'd5, 32'd5, 32'd5};
        @(posedge clk);
        #1;
        check("t5_reset_rready", 64'(chan_in_rready), 64'd0);
        check("t5_reset_wvalid", 64'(chan_out_wvalid), 64'd0);
        check("t5_reset_count", 64'(recv_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_done("t5", cyc);
        check("t5_sum", 64'(last_out), 64'd20);

        // Test 6: excess words stay in the FIFO
        reset_and_load('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6}, 0, 0);
        wait_done("t6", cyc);
        repeat (5) @(posedge clk);
        #1;
        check("t6_sum", 64'(last_out), 64'd10);
        check("t6_fifo_left", 64'(fifo_q.size()), 64'd2);
        check("t6_recv_count", 64'(recv_count), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
